// File: rtl/input_debouncer_pkg.sv
// input_debouncer_pkg: default constants and counter sizing shared by the debouncer.
package input_debouncer_pkg;
  localparam int STABLE_CYCLES_DEFAULT = 120000;
  localparam int SYNC_STAGES_DEFAULT = 2;
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronized, counter-filtered input with optional edge pulses.
// Edge registers exist only when INPUT_DEBOUNCER_EDGE_DETECT_EN is defined.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic RESET_VALUE = 1'b0,
  parameter int CW = cnt_width(STABLE_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic state_q, state_d, match, done;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    match = sync_q[SYNC_STAGES-1] == state_q;
    done = cnt_q == LAST;
    state_d = (!match && done) ? ~state_q : state_q;
    cnt_d = (match || done) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
      cnt_q <= '0;
      state_q <= RESET_VALUE;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
    end
  end
  assign level_out = state_q;
`ifdef INPUT_DEBOUNCER_EDGE_DETECT_EN
  logic rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    rise_d = state_d & ~state_q;
    fall_d = ~state_d & state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: NUM_INPUTS independent debounce channels plus a combined change flag.
// Edge outputs are live only when INPUT_DEBOUNCER_EDGE_DETECT_EN is defined.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter logic [NUM_INPUTS-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic                  any_change
);
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VALUE(RESET_VALUE[i])
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .raw_in(raw_in[i]),
      .level_out(level_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end
  assign any_change = |{rise_pulse, fall_pulse};
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of latency, glitch rejection, reset and channel independence.
module tb_input_debouncer;
`ifdef INPUT_DEBOUNCER_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset;
  logic [1:0] raw_in;
  logic [1:0] level_out, rise_pulse, fall_pulse;
  logic any_change;
  logic [1:0] exp_l, exp_r, exp_f;
  int errors = 0;
  int checks = 0;

  input_debouncer #(.NUM_INPUTS(2), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_VALUE(2'b00)) dut (
    .clock(clock), .reset(reset), .raw_in(raw_in), .level_out(level_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .any_change(any_change)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw_in = 2'b11;
    for (int n = 1; n <= 3; n++) begin
      step();
      checks++;
      if (level_out !== 2'b00) begin errors++; $display("FAIL reset_level n=%0d got=%b exp=00", n, level_out); end
      checks++;
      if ({rise_pulse, fall_pulse, any_change} !== 5'b0) begin errors++; $display("FAIL reset_pulses n=%0d got=%b exp=00000", n, {rise_pulse, fall_pulse, any_change}); end
    end
    reset = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_l = (n >= 6) ? 2'b11 : 2'b00;
      exp_r = (n == 6 && EDGE_EN) ? 2'b11 : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL post_reset_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if (rise_pulse !== exp_r) begin errors++; $display("FAIL post_reset_rise n=%0d got=%b exp=%b", n, rise_pulse, exp_r); end
      checks++;
      if (any_change !== |exp_r) begin errors++; $display("FAIL post_reset_any n=%0d got=%b exp=%b", n, any_change, |exp_r); end
    end
    raw_in = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_l = (n >= 6) ? 2'b00 : 2'b11;
      exp_f = (n == 6 && EDGE_EN) ? 2'b11 : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL reset_fall_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if (fall_pulse !== exp_f) begin errors++; $display("FAIL reset_fall_pulse n=%0d got=%b exp=%b", n, fall_pulse, exp_f); end
    end
  endtask

  task automatic test_step();
    raw_in = 2'b01;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_l = (n >= 6) ? 2'b01 : 2'b00;
      exp_r = (n == 6 && EDGE_EN) ? 2'b01 : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL step_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if (rise_pulse !== exp_r) begin errors++; $display("FAIL step_rise n=%0d got=%b exp=%b", n, rise_pulse, exp_r); end
      checks++;
      if (fall_pulse !== 2'b00) begin errors++; $display("FAIL step_fall n=%0d got=%b exp=00", n, fall_pulse); end
      checks++;
      if (any_change !== |exp_r) begin errors++; $display("FAIL step_any n=%0d got=%b exp=%b", n, any_change, |exp_r); end
    end
    raw_in = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_l = (n >= 6) ? 2'b00 : 2'b01;
      exp_f = (n == 6 && EDGE_EN) ? 2'b01 : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL step_fall_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if ({rise_pulse, fall_pulse} !== {2'b00, exp_f}) begin errors++; $display("FAIL step_fall_pulse n=%0d got=%b exp=%b", n, {rise_pulse, fall_pulse}, {2'b00, exp_f}); end
      checks++;
      if (any_change !== |exp_f) begin errors++; $display("FAIL step_fall_any n=%0d got=%b exp=%b", n, any_change, |exp_f); end
    end
  endtask

  task automatic test_glitch();
    raw_in = 2'b01;
    repeat (3) step();
    raw_in = 2'b00;
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if ({level_out, rise_pulse, fall_pulse, any_change} !== 7'b0) begin errors++; $display("FAIL glitch_quiet n=%0d got=%b exp=0000000", n, {level_out, rise_pulse, fall_pulse, any_change}); end
    end
    raw_in = 2'b01;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_l = (n >= 6) ? 2'b01 : 2'b00;
      exp_r = (n == 6 && EDGE_EN) ? 2'b01 : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL glitch_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if (rise_pulse !== exp_r) begin errors++; $display("FAIL glitch_rise n=%0d got=%b exp=%b", n, rise_pulse, exp_r); end
    end
    raw_in = 2'b00;
    repeat (7) step();
    checks++;
    if (level_out !== 2'b00) begin errors++; $display("FAIL glitch_restore got=%b exp=00", level_out); end
  endtask

  task automatic test_reset_mid();
    raw_in = 2'b10;
    repeat (2) step();
    reset = 1'b1;
    step();
    checks++;
    if ({level_out, rise_pulse, fall_pulse, any_change} !== 7'b0) begin errors++; $display("FAIL mid_reset_state got=%b exp=0000000", {level_out, rise_pulse, fall_pulse, any_change}); end
    reset = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_l = (n >= 6) ? 2'b10 : 2'b00;
      exp_r = (n == 6 && EDGE_EN) ? 2'b10 : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL mid_reset_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if (rise_pulse !== exp_r) begin errors++; $display("FAIL mid_reset_rise n=%0d got=%b exp=%b", n, rise_pulse, exp_r); end
    end
    raw_in = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_f = (n == 6 && EDGE_EN) ? 2'b10 : 2'b00;
      checks++;
      if (fall_pulse !== exp_f) begin errors++; $display("FAIL mid_reset_fall n=%0d got=%b exp=%b", n, fall_pulse, exp_f); end
    end
  endtask

  task automatic test_back_to_back();
    raw_in = 2'b11;
    repeat (2) step();
    raw_in = 2'b01;
    step();
    raw_in = 2'b11;
    for (int n = 4; n <= 10; n++) begin
      step();
      exp_l = {n >= 9, n >= 6};
      exp_r = EDGE_EN ? {n == 9, n == 6} : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL b2b_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if (rise_pulse !== exp_r) begin errors++; $display("FAIL b2b_rise n=%0d got=%b exp=%b", n, rise_pulse, exp_r); end
      checks++;
      if (any_change !== |exp_r) begin errors++; $display("FAIL b2b_any n=%0d got=%b exp=%b", n, any_change, |exp_r); end
    end
    raw_in = 2'b00;
    for (int n = 1; n <= 7; n++) begin
      step();
      exp_l = (n >= 6) ? 2'b00 : 2'b11;
      exp_f = (n == 6 && EDGE_EN) ? 2'b11 : 2'b00;
      checks++;
      if (level_out !== exp_l) begin errors++; $display("FAIL b2b_fall_level n=%0d got=%b exp=%b", n, level_out, exp_l); end
      checks++;
      if (fall_pulse !== exp_f) begin errors++; $display("FAIL b2b_fall_pulse n=%0d got=%b exp=%b", n, fall_pulse, exp_f); end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter NUM_INPUTS, default 2: number of independent input channels, range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 120000: consecutive stable clock cycles required before the output changes, range 1..2^24.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel, range 2..4.
REQ-004 Parameter RESET_VALUE, default all-zero, width NUM_INPUTS: per-channel level held during and after reset.
REQ-005 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port raw_in  input  NUM_INPUTS  asynchronous, bouncy inputs such as buttons.
REQ-008 Port level_out  output  NUM_INPUTS  debounced level per channel.
REQ-009 Port rise_pulse  output  NUM_INPUTS  one-cycle pulse when level_out goes 0->1.
REQ-010 Port fall_pulse  output  NUM_INPUTS  one-cycle pulse when level_out goes 1->0.
REQ-011 Port any_change  output  1  OR of all rise_pulse and fall_pulse bits.

Function
REQ-012 Each channel shall pass raw_in through a SYNC_STAGES-deep flop chain; the last stage is "sync".
REQ-013 Each channel shall hold a counter of width clog2(STABLE_CYCLES+1) and a state bit driving level_out.
REQ-014 When sync equals the state bit, the counter shall clear to 0 on that edge.
REQ-015 When sync differs from the state bit and counter < STABLE_CYCLES-1, the counter shall increment.
REQ-016 When sync differs from the state bit and counter == STABLE_CYCLES-1, the state bit shall invert and the counter shall clear on the same edge.
REQ-017 Latency: a clean input step held steady shall reach level_out exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge that samples the new value.
REQ-018 A mismatch lasting fewer than STABLE_CYCLES synchronized cycles shall leave level_out unchanged and restart the count from 0.
REQ-019 The counter shall never exceed STABLE_CYCLES-1, so it cannot wrap around.
REQ-020 With STABLE_CYCLES=1, level_out shall follow sync with one cycle of delay.
REQ-021 rise_pulse and fall_pulse shall be registered, asserted high for exactly the one cycle in which level_out first shows its new value, and never both high on one channel.
REQ-022 Channels shall be fully independent: simultaneous changes on any subset of channels shall each be handled per REQ-014..REQ-016.

Reset
REQ-023 While reset is high at a rising edge, all synchronizer stages and the state bits shall load RESET_VALUE, counters shall load 0, and rise_pulse, fall_pulse and any_change shall be 0.
REQ-024 Reset asserted mid-count shall discard the partial count, and the first edge after reset deassertion shall emit no pulse.
REQ-025 After reset, a raw_in that differs from RESET_VALUE shall need the full REQ-017 latency before level_out changes.

Configuration
REQ-026 Macro INPUT_DEBOUNCER_EDGE_DETECT_EN shall control whether edge detection is compiled in.
REQ-027 With the macro defined, rise_pulse, fall_pulse and any_change shall behave per REQ-021 and REQ-011.
REQ-028 Without the macro, rise_pulse, fall_pulse and any_change shall be driven constant 0 with no edge registers, and level_out behaviour shall be unchanged.

Structure
REQ-029 Package input_debouncer_pkg shall hold the default constants for STABLE_CYCLES and SYNC_STAGES and a function computing the counter width.
REQ-030 The per-channel logic (synchronizer, counter, state bit, edge registers) shall live in sub-module debounce_channel, instantiated NUM_INPUTS times by a generate loop.
REQ-031 The top level shall contain only the generate loop and the any_change reduction.

Verification (NUM_INPUTS=2, STABLE_CYCLES=4, SYNC_STAGES=2, RESET_VALUE=2'b00, macro defined unless noted)
REQ-032 Reset with raw_in=2'b11 held high for 3 cycles -> level_out=2'b00, all pulses 0, and the first pulse appears only after deassertion plus 6 edges.
REQ-033 raw_in[0] steps 0->1 and is held -> level_out[0]=1 exactly 6 edges later, rise_pulse[0] high for 1 cycle, any_change high for 1 cycle.
REQ-034 raw_in[0] high for 3 cycles, then low -> level_out[0] stays 0 with no pulses; a following 4-cycle-stable high causes a rise at +6 edges.
REQ-035 Reset asserted 2 cycles after a raw_in[1] rise, for 1 cycle -> counter cleared, level_out[1] rises 6 edges after reset deasserts.
REQ-036 Both channels step 0->1 on the same edge while raw_in[1] bounces low at cycle 3 -> level_out[0] rises at +6 edges and level_out[1] is delayed by the restart.
REQ-037 Same stimulus as REQ-033 built without INPUT_DEBOUNCER_EDGE_DETECT_EN -> level_out identical, rise_pulse, fall_pulse and any_change constant 0.
